// File: rtl/channel_receiver_if.sv
// Channel bundle for channel_receiver: incoming v/d/a channel, receive enable,
// outgoing v/d/a channel and occupancy status.
// The slave modport is the receiver's view; master is the environment's view.
interface channel_receiver_if #(
  parameter int N     = 4,
  parameter int DEPTH = 4
);
  logic [N-1:0]               in_d;
  logic                       in_v;
  logic                       in_a;
  logic                       accept;
  logic [N-1:0]               out_d;
  logic                       out_v;
  logic                       out_a;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       almost_full;

  modport master (
    output in_d, in_v, accept, out_a,
    input  in_a, out_d, out_v, count, almost_full
  );

  modport slave (
    input  in_d, in_v, accept, out_a,
    output in_a, out_d, out_v, count, almost_full
  );
endinterface

// File: rtl/channel_receiver.sv
// channel_receiver: receiving end of the valid/data-acknowledge Channel.
// in_a is combinational from local buffer state so one word per cycle can be
// taken; accepted words sit in a DEPTH-entry FIFO that is re-presented on the
// outgoing channel with first-word fall-through (one-cycle latency).
// Optional feature macro RX_COUNT_EN adds a 32-bit push counter (rx_count)
// with a synchronous clear (rx_count_clr) that has priority over increment.
module channel_receiver #(
  parameter int N        = 4,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3
) (
  input  logic               clk,
  input  logic               reset,
  channel_receiver_if.slave  ch
`ifdef RX_COUNT_EN
  ,
  input  logic               rx_count_clr,
  output logic [31:0]        rx_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_LEVEL);

  logic [N-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;

  // Handshake decode; in_a is gated by reset and never depends on out_a
  always_comb begin
    ch.in_a = reset & ch.accept & ch.in_v & (count_q != FULL_LVL);
    push    = ch.in_v & ch.in_a;
    pop     = ch.out_v & ch.out_a;
  end

  // Storage write; contents are deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= ch.in_d;
    end
  end

  // Pointers and occupancy; count disambiguates full from empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign ch.out_d       = mem[rd_ptr];
  assign ch.out_v       = (count_q != '0);
  assign ch.count       = count_q;
  assign ch.almost_full = (count_q >= AF_LVL);

`ifdef RX_COUNT_EN
  // Push counter; clear wins over a same-cycle push, wraps at 2^32
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_count <= '0;
    end else if (rx_count_clr) begin
      rx_count <= '0;
    end else if (push) begin
      rx_count <= rx_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_channel_receiver.sv
// Self-checking bench for channel_receiver (N=4, DEPTH=4, AF_LEVEL=3).
// Reference model: a queue of words plus the handshake rules; RX_COUNT_EN
// builds also model the push counter.
module tb_channel_receiver;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int AFL   = 3;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  logic [N-1:0] q[$];

  channel_receiver_if #(.N(N), .DEPTH(DEPTH)) ifc ();

`ifdef RX_COUNT_EN
  logic        rx_count_clr;
  logic [31:0] rx_count;
  logic [31:0] rxm;
`endif

  channel_receiver #(.N(N), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
    .clk         (clk),
    .reset       (reset),
    .ch          (ifc)
`ifdef RX_COUNT_EN
    ,
    .rx_count_clr(rx_count_clr),
    .rx_count    (rx_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit exp_in_a();
    return reset && ifc.accept && ifc.in_v && (q.size() < DEPTH);
  endfunction

  // Advance one clock edge and update the model from the driven inputs.
  task automatic tick();
    bit           push;
    bit           pop;
    logic [N-1:0] d;
    push = exp_in_a();
    pop  = ifc.out_a && (q.size() != 0);
    d    = ifc.in_d;
    @(posedge clk);
    if (!reset) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
    end
`ifdef RX_COUNT_EN
    if (!reset) rxm = '0;
    else if (rx_count_clr) rxm = '0;
    else if (push) rxm = rxm + 32'd1;
`endif
    #1;
  endtask

  task automatic drain();
    ifc.in_v  = 1'b0;
    ifc.out_a = 1'b1;
    for (int i = 0; i < 12 && q.size() != 0; i++) tick();
    ifc.out_a = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    ifc.in_v   = 1'b1;
    ifc.in_d   = 4'd3;
    ifc.accept = 1'b1;
    ifc.out_a  = 1'b0;
    #2;
    checks++; if (ifc.in_a !== 1'b0) begin errors++; $display("FAIL reset_in_a got=%b exp=0", ifc.in_a); end
    checks++; if (ifc.out_v !== 1'b0) begin errors++; $display("FAIL reset_out_v got=%b exp=0", ifc.out_v); end
    checks++; if (ifc.count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", ifc.count); end
    checks++; if (ifc.almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got=%b exp=0", ifc.almost_full); end
`ifdef RX_COUNT_EN
    checks++; if (rx_count !== 32'd0) begin errors++; $display("FAIL reset_rx_count got=%0d exp=0", rx_count); end
`endif
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++; if (ifc.in_a !== 1'b1) begin errors++; $display("FAIL release_in_a got=%b exp=1", ifc.in_a); end
    ifc.in_v = 1'b0;
    #1;
  endtask

  task automatic test_stream();
    ifc.out_a  = 1'b1;
    ifc.accept = 1'b1;
    for (int w = 1; w <= 8; w++) begin
      ifc.in_d = N'(w);
      ifc.in_v = 1'b1;
      #1;
      checks++; if (ifc.in_a !== 1'b1) begin errors++; $display("FAIL stream_in_a w=%0d got=%b exp=1", w, ifc.in_a); end
      checks++; if (ifc.count !== 3'(q.size()) || q.size() > 1) begin errors++; $display("FAIL stream_count w=%0d got=%0d exp=%0d", w, ifc.count, q.size()); end
      if (w > 1) begin
        checks++; if (ifc.out_v !== 1'b1 || ifc.out_d !== N'(w - 1)) begin errors++; $display("FAIL stream_out w=%0d got=%b/%0d exp=1/%0d", w, ifc.out_v, ifc.out_d, w - 1); end
      end
      tick();
    end
    ifc.in_v = 1'b0;
    #1;
    checks++; if (ifc.out_v !== 1'b1 || ifc.out_d !== 4'd8) begin errors++; $display("FAIL stream_last got=%b/%0d exp=1/8", ifc.out_v, ifc.out_d); end
    drain();
  endtask

  task automatic test_fill();
    logic [N-1:0] vals [5] = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    logic [N-1:0] rest [4] = '{4'd6, 4'd7, 4'd8, 4'd9};
    ifc.out_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifc.in_d = vals[i];
      ifc.in_v = 1'b1;
      #1;
      checks++; if (ifc.in_a !== 1'b1) begin errors++; $display("FAIL fill_in_a i=%0d got=%b exp=1", i, ifc.in_a); end
      checks++; if (ifc.almost_full !== (q.size() >= AFL)) begin errors++; $display("FAIL fill_af i=%0d got=%b exp=%b", i, ifc.almost_full, q.size() >= AFL); end
      tick();
    end
    ifc.in_d = vals[4];
    #1;
    checks++; if (ifc.count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", ifc.count); end
    checks++; if (ifc.in_a !== 1'b0) begin errors++; $display("FAIL full_in_a got=%b exp=0", ifc.in_a); end
    checks++; if (ifc.almost_full !== 1'b1) begin errors++; $display("FAIL full_af got=%b exp=1", ifc.almost_full); end
    ifc.out_a = 1'b1;
    #1;
    checks++; if (ifc.in_a !== 1'b0) begin errors++; $display("FAIL full_pop_in_a got=%b exp=0", ifc.in_a); end
    checks++; if (ifc.out_d !== 4'd5) begin errors++; $display("FAIL full_head got=%0d exp=5", ifc.out_d); end
    tick();
    ifc.out_a = 1'b0;
    #1;
    checks++; if (ifc.in_a !== 1'b1 || ifc.count !== 3'd3) begin errors++; $display("FAIL after_pop got=%b/%0d exp=1/3", ifc.in_a, ifc.count); end
    tick();
    ifc.in_v  = 1'b0;
    ifc.out_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ifc.out_v !== 1'b1 || ifc.out_d !== rest[i]) begin errors++; $display("FAIL fill_order i=%0d got=%b/%0d exp=1/%0d", i, ifc.out_v, ifc.out_d, rest[i]); end
      tick();
    end
    checks++; if (ifc.out_v !== 1'b0) begin errors++; $display("FAIL fill_empty got=%b exp=0", ifc.out_v); end
    ifc.out_a = 1'b0;
  endtask

  task automatic test_simul();
    ifc.out_a = 1'b0;
    ifc.in_v  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ifc.in_d = N'(10 + i);
      tick();
    end
    ifc.out_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ifc.in_d = N'(i + 1);
      #1;
      checks++; if (ifc.out_d !== q[0]) begin errors++; $display("FAIL simul_head i=%0d got=%0d exp=%0d", i, ifc.out_d, q[0]); end
      tick();
      checks++; if (ifc.count !== 3'd2) begin errors++; $display("FAIL simul_count i=%0d got=%0d exp=2", i, ifc.count); end
    end
    ifc.in_v = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (ifc.out_d !== q[0]) begin errors++; $display("FAIL simul_tail i=%0d got=%0d exp=%0d", i, ifc.out_d, q[0]); end
      tick();
    end
    drain();
  endtask

  task automatic test_wrap();
    int nsent = 0;
    int cyc   = 0;
    ifc.in_v = 1'b0;
    while ((nsent < 20 || q.size() != 0) && cyc < 400) begin
      bit pushed;
      if (!ifc.in_v && nsent < 20 && $urandom_range(0, 3) != 0) begin
        ifc.in_d = N'($urandom);
        ifc.in_v = 1'b1;
      end
      ifc.accept = ($urandom_range(0, 4) != 0);
      ifc.out_a  = $urandom_range(0, 1) != 0;
      #1;
      checks++; if (ifc.in_a !== exp_in_a()) begin errors++; $display("FAIL wrap_in_a cyc=%0d got=%b exp=%b", cyc, ifc.in_a, exp_in_a()); end
      checks++; if (ifc.count !== 3'(q.size())) begin errors++; $display("FAIL wrap_count cyc=%0d got=%0d exp=%0d", cyc, ifc.count, q.size()); end
      if (q.size() != 0) begin
        checks++; if (ifc.out_v !== 1'b1 || ifc.out_d !== q[0]) begin errors++; $display("FAIL wrap_out cyc=%0d got=%b/%0d exp=1/%0d", cyc, ifc.out_v, ifc.out_d, q[0]); end
      end
      pushed = exp_in_a();
      tick();
      if (pushed) begin
        nsent++;
        ifc.in_v = 1'b0;
      end
      cyc++;
    end
    checks++; if (nsent != 20 || q.size() != 0) begin errors++; $display("FAIL wrap_timeout sent=%0d left=%0d exp=20/0", nsent, q.size()); end
    ifc.accept = 1'b1;
    ifc.in_v   = 1'b0;
    ifc.out_a  = 1'b0;
  endtask

  task automatic test_accept();
    ifc.out_a  = 1'b0;
    ifc.accept = 1'b1;
    ifc.in_v   = 1'b1;
    ifc.in_d   = 4'd1;
    tick();
    ifc.in_d   = 4'd2;
    ifc.accept = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ifc.in_a !== 1'b0 || ifc.count !== 3'd1) begin errors++; $display("FAIL hold_off i=%0d got=%b/%0d exp=0/1", i, ifc.in_a, ifc.count); end
      tick();
    end
    ifc.accept = 1'b1;
    #1;
    checks++; if (ifc.in_a !== 1'b1) begin errors++; $display("FAIL resume_in_a got=%b exp=1", ifc.in_a); end
    tick();
    ifc.in_v  = 1'b0;
    checks++; if (ifc.count !== 3'd2) begin errors++; $display("FAIL resume_count got=%0d exp=2", ifc.count); end
    ifc.out_a = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      #1;
      checks++; if (ifc.out_d !== N'(i)) begin errors++; $display("FAIL accept_order i=%0d got=%0d exp=%0d", i, ifc.out_d, i); end
      tick();
    end
    ifc.out_a = 1'b0;
  endtask

  task automatic test_reset_mid();
    ifc.out_a = 1'b0;
    ifc.in_v  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ifc.in_d = N'(i + 12);
      tick();
    end
    ifc.in_v = 1'b0;
    checks++; if (ifc.count !== 3'd3) begin errors++; $display("FAIL pre_reset_count got=%0d exp=3", ifc.count); end
    #2;
    reset = 1'b0;
    q.delete();
    #1;
    checks++; if (ifc.count !== 3'd0 || ifc.out_v !== 1'b0 || ifc.almost_full !== 1'b0) begin errors++; $display("FAIL mid_reset got=%0d/%b/%b exp=0/0/0", ifc.count, ifc.out_v, ifc.almost_full); end
    tick();
    reset    = 1'b1;
    ifc.in_d = 4'hA;
    ifc.in_v = 1'b1;
    #1;
    checks++; if (ifc.in_a !== 1'b1) begin errors++; $display("FAIL post_reset_in_a got=%b exp=1", ifc.in_a); end
    tick();
    ifc.in_v = 1'b0;
    checks++; if (ifc.out_v !== 1'b1 || ifc.out_d !== 4'hA || ifc.count !== 3'd1) begin errors++; $display("FAIL post_reset_word got=%b/%0d/%0d exp=1/10/1", ifc.out_v, ifc.out_d, ifc.count); end
    drain();
  endtask

`ifdef RX_COUNT_EN
  task automatic test_rx_count();
    rx_count_clr = 1'b1;
    tick();
    rx_count_clr = 1'b0;
    checks++; if (rx_count !== rxm) begin errors++; $display("FAIL rx_clr0 got=%0d exp=%0d", rx_count, rxm); end
    ifc.out_a = 1'b1;
    ifc.in_v  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ifc.in_d = N'(i);
      tick();
    end
    checks++; if (rx_count !== 32'd10 || rxm != 32'd10) begin errors++; $display("FAIL rx_count10 got=%0d exp=10", rx_count); end
    rx_count_clr = 1'b1;
    tick();
    rx_count_clr = 1'b0;
    ifc.in_v     = 1'b0;
    checks++; if (rx_count !== 32'd0) begin errors++; $display("FAIL rx_clr_push got=%0d exp=0", rx_count); end
    drain();
  endtask
`endif

  initial begin
    errors     = 0;
    checks     = 0;
    reset      = 1'b0;
    ifc.in_d   = '0;
    ifc.in_v   = 1'b0;
    ifc.accept = 1'b0;
    ifc.out_a  = 1'b0;
`ifdef RX_COUNT_EN
    rx_count_clr = 1'b0;
    rxm          = '0;
`endif
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_fill();
    test_simul();
    test_wrap();
    test_accept();
    test_reset_mid();
`ifdef RX_COUNT_EN
    test_rx_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
